// File: rtl/axi_lite_byte_bridge_pkg.sv
// axi_lite_byte_bridge shared constants:
// FSM state codes, AXI response codes, aruser peek bit.
package axi_lite_byte_bridge_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_BYTE   = 3'd1;
  localparam logic [2:0] ST_WR_RESP   = 3'd2;
  localparam logic [2:0] ST_RD_STROBE = 3'd3;
  localparam logic [2:0] ST_RD_WAIT   = 3'd4;
  localparam logic [2:0] ST_RD_RESP   = 3'd5;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  localparam int         PEEK_BIT     = 0;

endpackage

// File: rtl/axi_lite_byte_bridge_byte_lane_picker.sv
// Lowest-set-lane priority encoder for the write strobe mask;
// returns the lane index and the mask with that lane cleared.
module byte_lane_picker (
  input  logic [3:0] mask_i,
  output logic [1:0] lane_o,
  output logic [3:0] rest_o
);

  always_comb begin
    lane_o = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_i[i]) lane_o = 2'(i);
    end
    rest_o = mask_i & ~(4'b0001 << lane_o);
  end

endmodule

// File: rtl/axi_lite_byte_bridge.sv
// AXI4-Lite slave to byte-wide register strobe bridge.
// Define BYTE_BRIDGE_DECERR_EN to reject out-of-range addresses with SLVERR.
module axi_lite_byte_bridge
  import axi_lite_byte_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           axi_s_awaddr,
  input  logic                  axi_s_awvalid,
  output logic                  axi_s_awready,
  input  logic [31:0]           axi_s_wdata,
  input  logic [3:0]            axi_s_wstrb,
  input  logic                  axi_s_wvalid,
  output logic                  axi_s_wready,
  output logic [1:0]            axi_s_bresp,
  output logic                  axi_s_bvalid,
  input  logic                  axi_s_bready,
  input  logic [31:0]           axi_s_araddr,
  input  logic [3:0]            axi_s_aruser,
  input  logic                  axi_s_arvalid,
  output logic                  axi_s_arready,
  output logic [31:0]           axi_s_rdata,
  output logic [1:0]            axi_s_rresp,
  output logic                  axi_s_rvalid,
  input  logic                  axi_s_rready,
  output logic [ADDR_WIDTH-1:0] reg_adr_o,
  output logic [7:0]            reg_dat_o,
  input  logic [7:0]            reg_dat_i,
  output logic                  reg_we_o,
  output logic                  reg_re_o
);

  logic [2:0]            state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  arready_q, arready_d;
  logic                  rr_rd_q, rr_rd_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            strb_q, strb_d;
  logic                  err_q, err_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] reg_adr_q, reg_adr_d;
  logic [7:0]            reg_dat_q, reg_dat_d;
  logic                  reg_we_q, reg_we_d;
  logic                  reg_re_q, reg_re_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  aw_err, ar_err;
  logic                  wr_elig, rd_elig;
  logic                  in_idle, issue, sample;
  logic [3:0]            pick_mask, rest;
  logic [1:0]            lane;
  logic [31:0]           cur_data;
  logic [ADDR_WIDTH-1:0] cur_adr;
  logic                  unused_ok;

`ifdef BYTE_BRIDGE_DECERR_EN
  assign aw_err = |axi_s_awaddr[31:ADDR_WIDTH];
  assign ar_err = |axi_s_araddr[31:ADDR_WIDTH];
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign unused_ok = ^{axi_s_awaddr[31:ADDR_WIDTH], axi_s_awaddr[1:0],
                       axi_s_araddr[31:ADDR_WIDTH], axi_s_aruser[3:1]};

  assign wr_elig = axi_s_awvalid && axi_s_wvalid;
  assign rd_elig = axi_s_arvalid;
  assign in_idle = state_q == ST_IDLE;

  // First byte issues straight from the AXI bus on accept.
  assign pick_mask = in_idle ? axi_s_wstrb : strb_q;
  assign cur_data  = in_idle ? axi_s_wdata : data_q;
  assign cur_adr   = in_idle ? axi_s_awaddr[ADDR_WIDTH-1:0] : adr_q;

  byte_lane_picker u_picker (
    .mask_i (pick_mask),
    .lane_o (lane),
    .rest_o (rest)
  );

  always_comb begin
    state_d   = state_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    rr_rd_d   = rr_rd_q;
    adr_d     = adr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    reg_adr_d = reg_adr_q;
    reg_dat_d = reg_dat_q;
    reg_we_d  = 1'b0;
    reg_re_d  = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    issue     = 1'b0;
    sample    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (awready_q) begin
          adr_d  = axi_s_awaddr[ADDR_WIDTH-1:0];
          data_d = axi_s_wdata;
          if (aw_err || axi_s_wstrb == 4'h0) begin
            state_d  = ST_WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = aw_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            state_d = ST_WR_BYTE;
            issue   = 1'b1;
          end
        end else if (arready_q) begin
          err_d     = ar_err;
          reg_adr_d = axi_s_araddr[ADDR_WIDTH-1:0];
          reg_re_d  = !axi_s_aruser[PEEK_BIT] && !ar_err;
          state_d   = ST_RD_STROBE;
        end else if (wr_elig && !(rr_rd_q && rd_elig)) begin
          awready_d = 1'b1;
          rr_rd_d   = 1'b1;
        end else if (rd_elig) begin
          arready_d = 1'b1;
          rr_rd_d   = 1'b0;
        end
      end
      ST_WR_BYTE: begin
        if (strb_q != 4'h0) begin
          issue = 1'b1;
        end else begin
          state_d  = ST_WR_RESP;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
        end
      end
      ST_WR_RESP: begin
        if (axi_s_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_STROBE: begin
        if (READ_LATENCY == 0) begin
          sample = 1'b1;
        end else begin
          cnt_d   = 2'(READ_LATENCY - 1);
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 2'd0) sample = 1'b1;
        else cnt_d = cnt_q - 2'd1;
      end
      ST_RD_RESP: begin
        if (axi_s_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      reg_we_d  = 1'b1;
      reg_adr_d = {cur_adr[ADDR_WIDTH-1:2], lane};
      reg_dat_d = cur_data[{lane, 3'b000} +: 8];
      strb_d    = rest;
    end
    if (sample) begin
      rdata_d  = err_q ? 32'h0 : {4{reg_dat_i}};
      rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      rvalid_d = 1'b1;
      state_d  = ST_RD_RESP;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      rr_rd_q   <= 1'b0;
      adr_q     <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      reg_adr_q <= '0;
      reg_dat_q <= '0;
      reg_we_q  <= 1'b0;
      reg_re_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      rr_rd_q   <= rr_rd_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      reg_adr_q <= reg_adr_d;
      reg_dat_q <= reg_dat_d;
      reg_we_q  <= reg_we_d;
      reg_re_q  <= reg_re_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi_s_awready = awready_q;
  assign axi_s_wready  = awready_q;
  assign axi_s_arready = arready_q;
  assign axi_s_bvalid  = bvalid_q;
  assign axi_s_bresp   = bresp_q;
  assign axi_s_rvalid  = rvalid_q;
  assign axi_s_rresp   = rresp_q;
  assign axi_s_rdata   = rdata_q;
  assign reg_adr_o     = reg_adr_q;
  assign reg_dat_o     = reg_dat_q;
  assign reg_we_o      = reg_we_q;
  assign reg_re_o      = reg_re_q;

endmodule

// File: doc/axi_lite_byte_bridge.md
Name: axi_lite_byte_bridge

Overview:
- AXI4-Lite slave that converts 32-bit AXI accesses into single-cycle byte-wide register strobes for the multi-port UART register array.
- Sits directly upstream of the per-port register decode: its reg_* outputs drive the shared address/data/strobe bus that fans out to each port.
- Serialises multi-byte writes into consecutive byte strobes.
- Supports side-effect-free "peek" reads via aruser.

Parameters:
- ADDR_WIDTH, 6, register-bus byte address width; 3 MSBs select the port, 3 LSBs select the register.
- READ_LATENCY, 1, cycles from reg_re_o to valid reg_dat_i; legal range 0..3.

Ports:
- aclk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- axi_s_awaddr  in  32  write byte address
- axi_s_awvalid/axi_s_awready  in/out  1  AW handshake
- axi_s_wdata  in  32  write data
- axi_s_wstrb  in  4  byte lane enables
- axi_s_wvalid/axi_s_wready  in/out  1  W handshake
- axi_s_bresp  out  2  write response
- axi_s_bvalid/axi_s_bready  out/in  1  B handshake
- axi_s_araddr  in  32  read byte address
- axi_s_aruser  in  4  bit0=1: peek (no reg_re_o)
- axi_s_arvalid/axi_s_arready  in/out  1  AR handshake
- axi_s_rdata  out  32  read byte replicated on all 4 lanes
- axi_s_rresp  out  2  read response
- axi_s_rvalid/axi_s_rready  out/in  1  R handshake
- reg_adr_o  out  ADDR_WIDTH  register byte address
- reg_dat_o  out  8  write byte
- reg_dat_i  in  8  read byte
- reg_we_o  out  1  write strobe, one cycle per byte
- reg_re_o  out  1  read strobe, one cycle, carries side effects

Behaviour:
- Reset (async assert, sync release on aclk): state IDLE; all ready/valid/strobes 0; bresp/rresp 2'b00; rdata 0; reg_adr_o 0; reg_dat_o 0; round-robin pointer = write.
- FSM states: IDLE, WR_BYTE, WR_RESP, RD_STROBE, RD_WAIT, RD_RESP.
- IDLE, write eligible when awvalid && wvalid both high. Accept both in the same cycle (awready = wready = 1 for one cycle); latch address, data and strobes.
- IDLE, read eligible when arvalid high.
- Both eligible: round-robin. Served class toggles the pointer; reset favours write.
- Write with wstrb==0: go directly to WR_RESP with no strobe.
- WR_BYTE: each cycle issue reg_we_o for the lowest remaining strobe bit n.
  - reg_adr_o = {awaddr[ADDR_WIDTH-1:2], n}; reg_dat_o = wdata[8n+7:8n]; clear bit n.
  - Go to WR_RESP when no bits remain, so a 4-byte write takes 4 consecutive strobe cycles.
- WR_RESP: bvalid=1, bresp OKAY; hold until bready; then IDLE.
- Read accept: arready=1 for one cycle; reg_adr_o = araddr[ADDR_WIDTH-1:0].
- RD_STROBE: reg_re_o=1 for one cycle, unless aruser[0]=1 (peek: address presented, no strobe). Then wait READ_LATENCY cycles (RD_WAIT skipped when 0).
- Sample reg_dat_i into rdata = {4{byte}} and enter RD_RESP.
- RD_RESP: rvalid=1 until rready; rdata and rresp held stable while rvalid && !rready.
- Only one transaction in flight; no ready is asserted outside IDLE.
- reg_we_o and reg_re_o are never high together.
- awvalid without wvalid (or vice versa): not accepted; wait in IDLE.
- Reset mid-transaction: transaction abandoned, no response issued, no further strobes.

Optional Feature:
- Macro: BYTE_BRIDGE_DECERR_EN.
- Defined: any access with address bits [31:ADDR_WIDTH] nonzero issues no strobes. The response is SLVERR (2'b10); for reads, rdata=0.
- Undefined: upper address bits ignored (aliasing); responses always OKAY.

Decomposition:
- Shared package: FSM state encoding, AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), peek bit index.
- One natural sub-module, byte_lane_picker: combinational priority encoder that takes the remaining strobe mask and returns the lowest lane index plus the cleared mask.

Test Plan:
- Write awaddr=0x09, wdata=0x0000_5A00, wstrb=0010 -> one reg_we_o with adr=0x09, dat=0x5A; bvalid with OKAY.
- Write awaddr=0x10, wstrb=1111, wdata=0x44332211 -> 4 consecutive strobes at adr 0x10..0x13 with data 11,22,33,44; then bvalid.
- Read araddr=0x0D, reg_dat_i=0x61, READ_LATENCY=1 -> one reg_re_o; rdata=0x61616161; rvalid held with rready low for 3 cycles, data stable.
- Peek read, aruser=0001 -> no reg_re_o; rdata reflects reg_dat_i.
- aw/w/ar all valid simultaneously for two back-to-back transactions -> write served first, then read.
- With BYTE_BRIDGE_DECERR_EN, araddr=0x100 -> no strobe, rresp=2'b10, rdata=0. Also: aresetn low during WR_BYTE -> strobes stop at once, bvalid stays 0.
